// File: rtl/tomasula_types.sv
// tomasula_types: shared result-bus types and widths for the Tomasulo core
package tomasula_types;

    localparam int ROB_TAG_W = 3;
    localparam int CDB_W     = 32;

    typedef logic [CDB_W-1:0] cdb_data;

    typedef struct packed {
        logic                 valid;
        logic [ROB_TAG_W-1:0] tag;
        cdb_data              data;
    } cdb_word;

endpackage

// File: rtl/cdb_arbiter_rr_picker.sv
// rr_picker: combinational round-robin picker, first set request at or after start wins
module rr_picker #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] start,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx
);

    logic [IW-1:0] j;

    // scan farthest-from-start first so the nearest requester overwrites the result
    always_comb begin
        grant = '0;
        idx   = '0;
        j     = '0;
        for (int k = N - 1; k >= 0; k--) begin
            j = IW'((int'(start) + k) % N);
            if (req[j]) begin
                grant    = '0;
                grant[j] = 1'b1;
                idx      = j;
            end
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: round-robin owner of the common data bus, one registered broadcast per cycle
module cdb_arbiter
    import tomasula_types::*;
#(
    parameter int NUM_REQ = 4,
    parameter int TAG_W   = ROB_TAG_W,
    parameter int DATA_W  = CDB_W
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*TAG_W-1:0]  req_tag,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      cdb_valid,
    output logic [TAG_W-1:0]          cdb_tag,
    output logic [DATA_W-1:0]         cdb_out
);

    localparam int PW = $clog2(NUM_REQ);

    logic [PW-1:0]      rr_ptr;
    logic [NUM_REQ-1:0] grant;
    logic [PW-1:0]      idx;
    logic               xfer;

    rr_picker #(.N(NUM_REQ), .IW(PW)) u_pick (
        .req   (req_valid),
        .start (rr_ptr),
        .grant (grant),
        .idx   (idx)
    );

    // grant is suppressed during reset and flush so nothing transfers in those cycles
    always_comb begin
        req_ready = (rst && !flush) ? grant : '0;
        xfer      = |req_ready;
    end

    // broadcast register and pointer advance; tag/data hold when idle
    always_ff @(posedge clk) begin
        if (!rst) begin
            cdb_valid <= 1'b0;
            cdb_tag   <= '0;
            cdb_out   <= '0;
            rr_ptr    <= '0;
        end else begin
            cdb_valid <= xfer;
            if (xfer) begin
                cdb_tag <= req_tag[idx*TAG_W +: TAG_W];
                cdb_out <= req_data[idx*DATA_W +: DATA_W];
                rr_ptr  <= (idx == PW'(NUM_REQ - 1)) ? '0 : idx + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: directed vector table plus corner sequences for cdb_arbiter
module tb_cdb_arbiter;

    logic        clk;
    logic        rst;
    logic        flush;
    logic [3:0]  req_valid;
    logic [11:0] req_tag;
    logic [127:0] req_data;
    logic [3:0]  req_ready;
    logic        cdb_valid;
    logic [2:0]  cdb_tag;
    logic [31:0] cdb_out;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic        rst;
        logic        flush;
        logic [3:0]  vld;
        logic [11:0] tags;
        logic [3:0]  exp_ready;
        logic        exp_cv;
        logic [2:0]  exp_ctag;
        logic [31:0] exp_cout;
    } vec_t;

    vec_t vecs [20];

    cdb_arbiter #(.NUM_REQ(4), .TAG_W(3), .DATA_W(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .req_valid (req_valid),
        .req_tag   (req_tag),
        .req_data  (req_data),
        .req_ready (req_ready),
        .cdb_valid (cdb_valid),
        .cdb_tag   (cdb_tag),
        .cdb_out   (cdb_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        vecs = '{
            '{1'b0, 1'b0, 4'b1111, 12'o7654, 4'b0000, 1'b0, 3'd0, 32'h00000000},
            '{1'b0, 1'b0, 4'b1111, 12'o7654, 4'b0000, 1'b0, 3'd0, 32'h00000000},
            '{1'b1, 1'b0, 4'b0100, 12'o0500, 4'b0100, 1'b1, 3'd5, 32'hDEADBEEF},
            '{1'b1, 1'b0, 4'b0000, 12'o0500, 4'b0000, 1'b0, 3'd5, 32'hDEADBEEF},
            '{1'b1, 1'b0, 4'b1001, 12'o3001, 4'b1000, 1'b1, 3'd3, 32'h44440003},
            '{1'b1, 1'b0, 4'b0001, 12'o3001, 4'b0001, 1'b1, 3'd1, 32'h11110000},
            '{1'b1, 1'b0, 4'b0011, 12'o0054, 4'b0010, 1'b1, 3'd5, 32'h22220001},
            '{1'b1, 1'b0, 4'b1001, 12'o3004, 4'b1000, 1'b1, 3'd3, 32'h44440003},
            '{1'b1, 1'b0, 4'b1111, 12'o7654, 4'b0001, 1'b1, 3'd4, 32'h11110000},
            '{1'b1, 1'b0, 4'b1111, 12'o7654, 4'b0010, 1'b1, 3'd5, 32'h22220001},
            '{1'b1, 1'b0, 4'b1111, 12'o7654, 4'b0100, 1'b1, 3'd6, 32'hDEADBEEF},
            '{1'b1, 1'b0, 4'b1111, 12'o7654, 4'b1000, 1'b1, 3'd7, 32'h44440003},
            '{1'b1, 1'b0, 4'b1111, 12'o7654, 4'b0001, 1'b1, 3'd4, 32'h11110000},
            '{1'b1, 1'b1, 4'b0011, 12'o0021, 4'b0000, 1'b0, 3'd4, 32'h11110000},
            '{1'b1, 1'b0, 4'b0011, 12'o0021, 4'b0010, 1'b1, 3'd2, 32'h22220001},
            '{1'b1, 1'b0, 4'b0001, 12'o0021, 4'b0001, 1'b1, 3'd1, 32'h11110000},
            '{1'b0, 1'b1, 4'b0010, 12'o0060, 4'b0000, 1'b0, 3'd0, 32'h00000000},
            '{1'b0, 1'b0, 4'b0010, 12'o0060, 4'b0000, 1'b0, 3'd0, 32'h00000000},
            '{1'b1, 1'b0, 4'b0010, 12'o0060, 4'b0010, 1'b1, 3'd6, 32'h22220001},
            '{1'b1, 1'b0, 4'b0000, 12'o0060, 4'b0000, 1'b0, 3'd6, 32'h22220001}
        };
        req_data  = {32'h44440003, 32'hDEADBEEF, 32'h22220001, 32'h11110000};
        rst       = 1'b0;
        flush     = 1'b0;
        req_valid = '0;
        req_tag   = '0;

        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            rst       = vecs[i].rst;
            flush     = vecs[i].flush;
            req_valid = vecs[i].vld;
            req_tag   = vecs[i].tags;
            #1;
            chk($sformatf("v%0d req_ready", i), 32'(req_ready), 32'(vecs[i].exp_ready));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d cdb_valid", i), 32'(cdb_valid), 32'(vecs[i].exp_cv));
            chk($sformatf("v%0d cdb_tag", i), 32'(cdb_tag), 32'(vecs[i].exp_ctag));
            chk($sformatf("v%0d cdb_out", i), cdb_out, vecs[i].exp_cout);
        end

        // broadcast visible in the flush cycle completes; the flush only blocks the new grant
        @(negedge clk);
        req_valid = 4'b0100;
        req_tag   = 12'o0300;
        #1;
        chk("pre_flush req_ready", 32'(req_ready), 32'h4);
        @(posedge clk);
        #1;
        chk("pre_flush cdb_valid", 32'(cdb_valid), 32'h1);
        @(negedge clk);
        flush     = 1'b1;
        req_valid = 4'b0000;
        #1;
        chk("flush_cycle req_ready", 32'(req_ready), 32'h0);
        chk("flush_cycle cdb_valid", 32'(cdb_valid), 32'h1);
        chk("flush_cycle cdb_tag", 32'(cdb_tag), 32'h3);
        @(posedge clk);
        #1;
        chk("post_flush cdb_valid", 32'(cdb_valid), 32'h0);
        chk("post_flush cdb_tag", 32'(cdb_tag), 32'h3);

        // request dropped before its grant edge: no transfer, pointer stays at 3
        @(negedge clk);
        flush     = 1'b0;
        req_valid = 4'b1000;
        #1;
        chk("drop req_ready", 32'(req_ready), 32'h8);
        req_valid = 4'b0000;
        #1;
        chk("drop req_ready_gone", 32'(req_ready), 32'h0);
        @(posedge clk);
        #1;
        chk("drop cdb_valid", 32'(cdb_valid), 32'h0);
        @(negedge clk);
        req_valid = 4'b0011;
        req_tag   = 12'o0021;
        #1;
        chk("rearb req_ready", 32'(req_ready), 32'h1);
        @(posedge clk);
        #1;
        chk("rearb cdb_valid", 32'(cdb_valid), 32'h1);
        chk("rearb cdb_tag", 32'(cdb_tag), 32'h1);
        chk("rearb cdb_out", cdb_out, 32'h11110000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
